// File: rtl/lsu_pkg.sv
// Shared types and helpers for the lsu_mmio load/store unit: FSM states,
// access-size and fault-cause encodings, and byte-enable generation.
package lsu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RAM_REQ,
    ST_RAM_RD,
    ST_IO_REQ,
    ST_DONE,
    ST_FAULT
  } state_e;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam logic [1:0] FC_NONE  = 2'b00;
  localparam logic [1:0] FC_MISAL = 2'b01;
  localparam logic [1:0] FC_TMO   = 2'b10;
  localparam logic [1:0] FC_UNMAP = 2'b11;

  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_B:    byte_en = 4'b0001 << off;
      SZ_H:    byte_en = 4'b0011 << {off[1], 1'b0};
      default: byte_en = 4'b1111;
    endcase
  endfunction

  // Size 2'b11 is handled exactly like SZ_W.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_B:    misaligned = 1'b0;
      SZ_H:    misaligned = off[0];
      SZ_W:    misaligned = |off;
      default: misaligned = |off;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte-lane steering: replicates store data across lanes (load_i=0) or
// shifts, masks and sign/zero-extends load data (load_i=1).
module lsu_lane
  import lsu_pkg::*;
(
  input  logic        load_i,
  input  logic [1:0]  size_i,
  input  logic        sign_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o
);

  logic [31:0] shifted;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    shifted = data_i >> {off_i, 3'b000};
    data_o  = data_i;
    if (load_i) begin
      case (size_i)
        SZ_B:    data_o = {{24{sign_i & shifted[7]}}, shifted[7:0]};
        SZ_H:    data_o = {{16{sign_i & shifted[15]}}, shifted[15:0]};
        default: data_o = shifted;
      endcase
    end else begin
      case (size_i)
        SZ_B:    data_o = {4{data_i[7:0]}};
        SZ_H:    data_o = {2{data_i[15:0]}};
        default: data_o = data_i;
      endcase
    end
  end

endmodule

// File: rtl/lsu_mmio.sv
// Stalling load/store stage decoding each access to RAM or one of N_CH MMIO
// channels. Define LSU_TIMEOUT_EN to add the IO acknowledge-wait timeout.
module lsu_mmio
  import lsu_pkg::*;
#(
  parameter int                WIDTH        = 32,
  parameter int                N_CH         = 2,
  parameter logic [WIDTH-1:0]  IO_BASE      = 32'h0000_0400,
  parameter int                CH_SPAN_LOG2 = 4,
  parameter int                TIMEOUT      = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  input  logic                     req_we,
  input  logic [1:0]               req_size,
  input  logic                     req_sign,
  input  logic [WIDTH-1:0]         req_addr,
  input  logic [WIDTH-1:0]         req_wdata,
  output logic                     stall,
  output logic                     rsp_valid,
  output logic [WIDTH-1:0]         rsp_rdata,
  output logic                     fault,
  output logic [1:0]               fault_cause,
  output logic                     ram_en,
  output logic                     ram_we,
  output logic [3:0]               ram_be,
  output logic [WIDTH-1:0]         ram_addr,
  output logic [WIDTH-1:0]         ram_wdata,
  input  logic [WIDTH-1:0]         ram_rdata,
  output logic [N_CH-1:0]          io_req,
  input  logic [N_CH-1:0]          io_ack,
  output logic                     io_we,
  output logic [3:0]               io_be,
  output logic [CH_SPAN_LOG2-1:0]  io_addr,
  output logic [WIDTH-1:0]         io_wdata,
  input  logic [N_CH*WIDTH-1:0]    io_rdata
);

  localparam int               CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [WIDTH-1:0] IO_SPAN = WIDTH'(N_CH) << CH_SPAN_LOG2;

  if (WIDTH != 32) begin : g_bad_width
    $error("lsu_mmio: WIDTH must be 32");
  end
  if (N_CH < 1 || N_CH > 8) begin : g_bad_nch
    $error("lsu_mmio: N_CH must be 1..8");
  end
  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_tmo
    $error("lsu_mmio: TIMEOUT must be 1..65535");
  end

  state_e            state_q, state_d;
  logic              we_q, sign_q;
  logic [1:0]        size_q, cause_q;
  logic [3:0]        be_q;
  logic [WIDTH-1:0]  addr_q, wdata_q, rdata_q;
  logic [CH_W-1:0]   ch_q;

  // Decode of the incoming request; only used in the acceptance cycle.
  logic [WIDTH-1:0]  rel;
  logic              is_ram, is_io, misal;
  logic [CH_W-1:0]   ch_d;
  logic [WIDTH-1:0]  st_lane, ld_raw, ld_lane;

  assign rel    = req_addr - IO_BASE;
  assign is_ram = req_addr < IO_BASE;
  assign is_io  = !is_ram && (rel < IO_SPAN);
  assign ch_d   = CH_W'(rel >> CH_SPAN_LOG2);
  assign misal  = misaligned(req_size, req_addr[1:0]);

  logic io_active, ack_sel, tmo, accept, ld_latch;

  assign io_active = (state_q == ST_IO_REQ);
  assign ack_sel   = io_active && io_ack[ch_q];
  assign accept    = (state_q == ST_IDLE) && req_valid;
  assign ld_latch  = (state_q == ST_RAM_RD) || (ack_sel && !we_q);

  lsu_lane u_wr_lane (
    .load_i (1'b0),
    .size_i (req_size),
    .sign_i (req_sign),
    .off_i  (req_addr[1:0]),
    .data_i (req_wdata),
    .data_o (st_lane)
  );

  assign ld_raw = io_active ? io_rdata[int'(ch_q)*WIDTH +: WIDTH] : ram_rdata;

  lsu_lane u_rd_lane (
    .load_i (1'b1),
    .size_i (size_q),
    .sign_i (sign_q),
    .off_i  (addr_q[1:0]),
    .data_i (ld_raw),
    .data_o (ld_lane)
  );

`ifdef LSU_TIMEOUT_EN
  logic [15:0] cnt_q;

  // Zero outside IO_REQ, so it always starts from 0 on entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         cnt_q <= '0;
    else if (!io_active) cnt_q <= '0;
    else                cnt_q <= cnt_q + 16'd1;
  end

  assign tmo = io_active && (cnt_q == 16'(TIMEOUT - 1));
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (misal || !(is_ram || is_io)) state_d = ST_FAULT;
          else if (is_ram)                 state_d = ST_RAM_REQ;
          else                             state_d = ST_IO_REQ;
        end
      end
      ST_RAM_REQ: state_d = we_q ? ST_DONE : ST_RAM_RD;
      ST_RAM_RD:  state_d = ST_DONE;
      ST_IO_REQ: begin
        // An acknowledge in the expiry cycle still completes normally.
        if (ack_sel)  state_d = ST_DONE;
        else if (tmo) state_d = ST_FAULT;
      end
      default:    state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      sign_q  <= 1'b0;
      size_q  <= SZ_B;
      cause_q <= FC_NONE;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ch_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q    <= req_we;
        sign_q  <= req_sign;
        size_q  <= req_size;
        addr_q  <= req_addr;
        wdata_q <= st_lane;
        be_q    <= byte_en(req_size, req_addr[1:0]);
        ch_q    <= ch_d;
        cause_q <= misal ? FC_MISAL : FC_UNMAP;
        rdata_q <= '0;
      end
      if (ld_latch) rdata_q <= ld_lane;
      if (tmo && !ack_sel) cause_q <= FC_TMO;
    end
  end

  assign rsp_valid   = (state_q == ST_DONE) || (state_q == ST_FAULT);
  assign rsp_rdata   = rdata_q;
  assign fault       = (state_q == ST_FAULT);
  assign fault_cause = fault ? cause_q : FC_NONE;
  // Gated by reset so the core sees no stall while the unit is held in reset.
  assign stall       = reset & req_valid & ~rsp_valid;

  assign ram_en    = (state_q == ST_RAM_REQ);
  assign ram_we    = ram_en & we_q;
  assign ram_be    = ram_en ? be_q : 4'b0000;
  assign ram_addr  = {addr_q[WIDTH-1:2], 2'b00};
  assign ram_wdata = wdata_q;

  assign io_req   = io_active ? (N_CH'(1) << ch_q) : '0;
  assign io_we    = io_active & we_q;
  assign io_be    = io_active ? be_q : 4'b0000;
  assign io_addr  = addr_q[CH_SPAN_LOG2-1:0];
  assign io_wdata = wdata_q;

endmodule
